// File: rtl/delta_scale.sv
// delta_scale: sequential 30x90-bit scaler, one 30x30 partial product per cycle.
// Accepts plaintext coefficients and emits exact 120-bit lifted coefficients
// with valid/ready handshakes on both sides. out_last marks index N-1.
module delta_scale #(
    parameter int unsigned IN_W    = 30,
    parameter int unsigned DELTA_W = 90,
    parameter int unsigned OUT_W   = 120,
    parameter int unsigned N       = 1024
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [DELTA_W-1:0] delta,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [IN_W-1:0]    in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   out_data,
    output logic               out_last
);

    localparam int unsigned IDX_W = $clog2(N);
    localparam int unsigned PP_W  = 2 * IN_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [IN_W-1:0]      a_q, a_d;
    logic [OUT_W-1:0]     acc_q, acc_d;
    logic [1:0]           step_q, step_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DELTA_W-1:0]   delta_q, delta_d;
    logic                 last_q, last_d;

    logic                 accept_c;
    logic [IN_W-1:0]      limb_c;
    logic [PP_W-1:0]      pp_c;
    logic [OUT_W-1:0]     pp_shifted_c;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept_c) state_d = MUL;
            MUL:  if (step_q == 2'd2) state_d = OUT;
            OUT:  if (out_ready) state_d = in_valid ? MUL : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register; in OUT a new
    // coefficient may be taken on the same edge the result leaves.
    always_comb begin
        out_valid = 1'b0;
        in_ready  = 1'b0;
        unique case (state_q)
            IDLE: in_ready = 1'b1;
            OUT: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
            end
            default: ;
        endcase
    end

    assign accept_c = in_valid && in_ready;

    // Select the delta limb and its weight for the current step
    always_comb begin
        limb_c       = '0;
        pp_c         = PP_W'(a_q) * PP_W'(limb_c);
        pp_shifted_c = '0;
        unique case (step_q)
            2'd0: begin
                limb_c       = delta_q[IN_W-1:0];
                pp_c         = PP_W'(a_q) * PP_W'(limb_c);
                pp_shifted_c = OUT_W'(pp_c);
            end
            2'd1: begin
                limb_c       = delta_q[2*IN_W-1:IN_W];
                pp_c         = PP_W'(a_q) * PP_W'(limb_c);
                pp_shifted_c = OUT_W'(pp_c) << IN_W;
            end
            2'd2: begin
                limb_c       = delta_q[3*IN_W-1:2*IN_W];
                pp_c         = PP_W'(a_q) * PP_W'(limb_c);
                pp_shifted_c = OUT_W'(pp_c) << (2 * IN_W);
            end
            default: ;
        endcase
    end

    // Datapath next-state: capture on acceptance, accumulate during MUL
    always_comb begin
        a_d     = a_q;
        acc_d   = acc_q;
        step_d  = step_q;
        idx_d   = idx_q;
        delta_d = delta_q;
        last_d  = last_q;
        if (accept_c) begin
            a_d    = in_data;
            acc_d  = '0;
            step_d = 2'd0;
            idx_d  = idx_q + IDX_W'(1);
            last_d = (idx_q == IDX_W'(N - 1));
            if (idx_q == '0) begin
                delta_d = delta;
            end
        end else if (state_q == MUL) begin
            acc_d  = acc_q + pp_shifted_c;
            step_d = step_q + 2'd1;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q     <= '0;
            acc_q   <= '0;
            step_q  <= 2'd0;
            idx_q   <= '0;
            delta_q <= '0;
            last_q  <= 1'b0;
        end else begin
            a_q     <= a_d;
            acc_q   <= acc_d;
            step_q  <= step_d;
            idx_q   <= idx_d;
            delta_q <= delta_d;
            last_q  <= last_d;
        end
    end

    assign out_data = acc_q;
    assign out_last = last_q;

endmodule

// File: tb/tb_delta_scale.sv
// Directed self-checking bench for delta_scale.
module tb_delta_scale;

    localparam int unsigned IN_W    = 30;
    localparam int unsigned DELTA_W = 90;
    localparam int unsigned OUT_W   = 120;
    localparam int unsigned N       = 1024;

    logic               clk;
    logic               reset;
    logic [DELTA_W-1:0] delta;
    logic               in_valid;
    logic               in_ready;
    logic [IN_W-1:0]    in_data;
    logic               out_valid;
    logic               out_ready;
    logic [OUT_W-1:0]   out_data;
    logic               out_last;

    int n_checks;
    int n_fail;

    delta_scale #(
        .IN_W(IN_W), .DELTA_W(DELTA_W), .OUT_W(OUT_W), .N(N)
    ) dut (
        .clk(clk), .reset(reset), .delta(delta),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 30'd5;
        delta     = 90'd1;
        out_ready = 1'b1;
        repeat (3) tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data got %0h want 0", out_data); end
        n_checks++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last got %0b want 0", out_last); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
        in_valid = 1'b0;
        reset    = 1'b1;
        repeat (4) tick();
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_idle got valid=%0b ready=%0b want 0/1", out_valid, in_ready); end
    endtask

    task automatic test_unit();
        do_reset();
        delta    = 90'd1;
        in_data  = 30'd5;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL unit_mul_in_ready got %0b want 0", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL unit_lat1_valid got %0b want 0", out_valid); end
        tick();
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL unit_lat2_valid got %0b want 0", out_valid); end
        tick();
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL unit_lat3_valid got %0b want 1", out_valid); end
        n_checks++; if (out_data !== 120'd5) begin n_fail++; $display("FAIL unit_data got %0h want 5", out_data); end
        n_checks++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL unit_last got %0b want 0", out_last); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL unit_drain got valid=%0b ready=%0b want 0/1", out_valid, in_ready); end
    endtask

    task automatic test_max_operands();
        logic [OUT_W-1:0] exp;
        exp = ~120'd0 - (120'd1 << 90) - (120'd1 << 30) + 120'd2;
        do_reset();
        delta    = ~90'd0;
        in_data  = ~30'd0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        n_checks++; if (out_valid !== 1'b1 || out_data !== exp) begin n_fail++; $display("FAIL max_operands got v=%0b %0h want %0h", out_valid, out_data, exp); end
    endtask

    task automatic test_cross_limb_backpressure();
        logic [OUT_W-1:0] exp;
        logic [OUT_W-1:0] held;
        exp = 120'd3 << 60;
        do_reset();
        delta    = 90'd1 << 60;
        in_data  = 30'd3;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        n_checks++; if (out_valid !== 1'b1 || out_data !== exp) begin n_fail++; $display("FAIL cross_limb got v=%0b %0h want %0h", out_valid, out_data, exp); end
        held     = exp;
        in_valid = 1'b1;
        in_data  = 30'd7;
        delta    = 90'd5;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++; if (out_valid !== 1'b1 || out_data !== held || in_ready !== 1'b0 || out_last !== 1'b0) begin
                n_fail++; $display("FAIL backpressure_hold cyc %0d got v=%0b r=%0b %0h want v=1 r=0 %0h", i, out_valid, in_ready, out_data, held);
            end
        end
        out_ready = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_in_ready got %0b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_same_edge got v=%0b r=%0b want 0/0", out_valid, in_ready); end
        repeat (3) tick();
        n_checks++; if (out_valid !== 1'b1 || out_data !== (120'd7 << 60)) begin n_fail++; $display("FAIL bp_second_result got v=%0b %0h want %0h", out_valid, out_data, 120'd7 << 60); end
        tick();
        out_ready = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain got %0b want 0", out_valid); end
    endtask

    task automatic test_delta_latch();
        do_reset();
        out_ready = 1'b1;
        delta     = 90'd100;
        in_data   = 30'd2;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        delta    = 90'd999;
        repeat (3) tick();
        n_checks++; if (out_data !== 120'd200) begin n_fail++; $display("FAIL latch_first got %0h want c8", out_data); end
        in_data  = 30'd3;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        n_checks++; if (out_valid !== 1'b1 || out_data !== 120'd300) begin n_fail++; $display("FAIL latch_old_delta got v=%0b %0h want 12c", out_valid, out_data); end
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_full_polynomial();
        logic [DELTA_W-1:0] da;
        logic [DELTA_W-1:0] db;
        logic [IN_W-1:0]    a;
        logic [OUT_W-1:0]   exp;
        logic               exp_last;
        da = DELTA_W'({$urandom, $urandom, $urandom});
        db = DELTA_W'({$urandom, $urandom, $urandom});
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i <= int'(N); i++) begin
            a       = IN_W'($urandom);
            in_data = a;
            if (i == 0) delta = da;
            else if (i == int'(N)) delta = db;
            else delta = DELTA_W'({$urandom, $urandom, $urandom});
            exp      = (i == int'(N)) ? (OUT_W'(a) * OUT_W'(db)) : (OUT_W'(a) * OUT_W'(da));
            exp_last = (i == int'(N) - 1);
            tick();
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL poly_gap1 coef %0d got %0b want 0", i, out_valid); end
            tick();
            tick();
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL poly_gap3 coef %0d got %0b want 0", i, out_valid); end
            tick();
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL poly_valid coef %0d got %0b want 1", i, out_valid); end
            n_checks++; if (out_data !== exp) begin n_fail++; $display("FAIL poly_data coef %0d got %0h want %0h", i, out_data, exp); end
            n_checks++; if (out_last !== exp_last) begin n_fail++; $display("FAIL poly_last coef %0d got %0b want %0b", i, out_last, exp_last); end
        end
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_mul();
        do_reset();
        out_ready = 1'b1;
        delta     = 90'd7;
        in_data   = 30'd9;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        delta    = 90'd13;
        in_data  = 30'd11;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_valid got %0b want 0", out_valid); end
        n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL midreset_data got %0h want 0", out_data); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_in_ready got %0b want 1", in_ready); end
        tick();
        reset    = 1'b1;
        delta    = 90'd6;
        in_data  = 30'd4;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        n_checks++; if (out_valid !== 1'b1 || out_data !== 120'd24) begin n_fail++; $display("FAIL midreset_relatch got v=%0b %0h want 18", out_valid, out_data); end
        n_checks++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL midreset_last got %0b want 0", out_last); end
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b0;
        delta     = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        test_reset();
        test_unit();
        test_max_operands();
        test_cross_limb_backpressure();
        test_delta_latch();
        test_full_polynomial();
        test_reset_mid_mul();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
